// File: rtl/axi_reg_access_arbiter.sv
// Round-robin arbiter that shares the register bank's internal operation port
// among several on-chip clients, each using a req/ack handshake.
module axi_reg_access_arbiter #(
  parameter int NUMBER_OF_CLIENTS   = 2,
  parameter int NUMBER_OF_REGISTERS = 6,
  parameter int C_S_AXI_DATA_WIDTH  = 32
) (
  input  logic                                            S_AXI_ACLK,
  input  logic                                            S_AXI_ARESETN,
  input  logic [NUMBER_OF_CLIENTS-1:0]                    client_req,
  input  logic [2*NUMBER_OF_CLIENTS-1:0]                  client_op,
  input  logic [8*NUMBER_OF_CLIENTS-1:0]                  client_reg,
  input  logic [C_S_AXI_DATA_WIDTH*NUMBER_OF_CLIENTS-1:0] client_wdata,
  output logic [NUMBER_OF_CLIENTS-1:0]                    client_ack,
  output logic                                            client_err,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                   client_rdata,
  output logic                                            busy,
  output logic [1:0]                                      register_operation,
  output logic [7:0]                                      register_number,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                   register_write,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                   register_read
);

  localparam int N  = NUMBER_OF_CLIENTS;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0]   NUM_CLIENTS = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_CLIENT = IW'(N - 1);
  localparam logic [7:0]    NUM_REGS    = 8'(NUMBER_OF_REGISTERS);
  localparam logic [1:0] OP_NONE     = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] OP_COMPLETE = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, COMPLETE, ERROR_ACK} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rrPtr_q, rrPtr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [1:0]    op_q, op_d;
  logic [1:0]    regOp_q, regOp_d;
  logic [7:0]    regNum_q, regNum_d;
  logic [DW-1:0] regWrite_q, regWrite_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;

  logic          reqFound;
  logic [IW-1:0] reqGrant;
  logic [IW:0]   searchIdx;
  logic [1:0]    selOp;
  logic [7:0]    selReg;
  logic [DW-1:0] selWdata;
  logic          selIllegal;
  logic [IW-1:0] nextPtr;

  // Priority starts at rrPtr and wraps, so the last-served client goes to the back of the line.
  always_comb begin
    reqFound  = 1'b0;
    reqGrant  = '0;
    searchIdx = '0;
    for (int k = 0; k < N; k++) begin
      searchIdx = {1'b0, rrPtr_q} + (IW+1)'(k);
      if (searchIdx >= NUM_CLIENTS) begin
        searchIdx = searchIdx - NUM_CLIENTS;
      end
      if (!reqFound && client_req[searchIdx[IW-1:0]]) begin
        reqFound = 1'b1;
        reqGrant = searchIdx[IW-1:0];
      end
    end
  end

  assign selOp      = client_op[int'(reqGrant)*2 +: 2];
  assign selReg     = client_reg[int'(reqGrant)*8 +: 8];
  assign selWdata   = client_wdata[int'(reqGrant)*DW +: DW];
  assign selIllegal = (selReg >= NUM_REGS) || !((selOp == OP_READ) || (selOp == OP_WRITE));
  assign nextPtr    = (grant_q == LAST_CLIENT) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    grant_d    = grant_q;
    op_d       = op_q;
    regOp_d    = regOp_q;
    regNum_d   = regNum_q;
    regWrite_d = regWrite_q;
    ack_d      = '0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        regOp_d    = OP_NONE;
        regNum_d   = '0;
        regWrite_d = '0;
        if (reqFound) begin
          grant_d = reqGrant;
          op_d    = selOp;
          if (selIllegal) begin
            state_d         = ERROR_ACK;
            ack_d[reqGrant] = 1'b1;
            err_d           = 1'b1;
            rdata_d         = '0;
          end else begin
            state_d    = ISSUE;
            regOp_d    = selOp;
            regNum_d   = selReg;
            regWrite_d = (selOp == OP_WRITE) ? selWdata : '0;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
        regOp_d = OP_NONE;
      end
      // Read data from the bank is valid now, one cycle after the read op.
      CAPTURE: begin
        state_d        = COMPLETE;
        regOp_d        = OP_COMPLETE;
        ack_d[grant_q] = 1'b1;
        err_d          = 1'b0;
        rdata_d        = (op_q == OP_READ) ? register_read : '0;
      end
      COMPLETE: begin
        state_d    = IDLE;
        regOp_d    = OP_NONE;
        regNum_d   = '0;
        regWrite_d = '0;
        rrPtr_d    = nextPtr;
      end
      ERROR_ACK: begin
        state_d = IDLE;
        rrPtr_d = nextPtr;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      grant_q    <= '0;
      op_q       <= '0;
      regOp_q    <= '0;
      regNum_q   <= '0;
      regWrite_q <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grant_q    <= grant_d;
      op_q       <= op_d;
      regOp_q    <= regOp_d;
      regNum_q   <= regNum_d;
      regWrite_q <= regWrite_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign client_ack         = ack_q;
  assign client_err         = err_q;
  assign client_rdata       = rdata_q;
  assign busy               = busy_q;
  assign register_operation = regOp_q;
  assign register_number    = regNum_q;
  assign register_write     = regWrite_q;

endmodule

// File: tb/tb_axi_reg_access_arbiter.sv
// Self-checking bench for axi_reg_access_arbiter: directed scenarios followed by
// random client traffic, all checked against a transaction-level model.
module tb_axi_reg_access_arbiter;

  localparam int N  = 2;
  localparam int NR = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    client_req;
  logic [2*N-1:0]  client_op;
  logic [8*N-1:0]  client_reg;
  logic [DW*N-1:0] client_wdata;
  logic [N-1:0]    client_ack;
  logic            client_err;
  logic [DW-1:0]   client_rdata;
  logic            busy;
  logic [1:0]      register_operation;
  logic [7:0]      register_number;
  logic [DW-1:0]   register_write;
  logic [DW-1:0]   register_read = '0;

  logic [DW-1:0]   bankMem [NR] = '{default: '0};

  bit              reqOn [N];
  logic [1:0]      cOp   [N];
  logic [7:0]      cReg  [N];
  logic [DW-1:0]   cData [N];

  int              modelPtr;
  logic [DW-1:0]   modelBank [NR];
  bit              randomExtra;
  int              total;
  int              bad;

  axi_reg_access_arbiter #(
    .NUMBER_OF_CLIENTS  (N),
    .NUMBER_OF_REGISTERS(NR),
    .C_S_AXI_DATA_WIDTH (DW)
  ) dut (
    .S_AXI_ACLK        (clk),
    .S_AXI_ARESETN     (rst_n),
    .client_req        (client_req),
    .client_op         (client_op),
    .client_reg        (client_reg),
    .client_wdata      (client_wdata),
    .client_ack        (client_ack),
    .client_err        (client_err),
    .client_rdata      (client_rdata),
    .busy              (busy),
    .register_operation(register_operation),
    .register_number   (register_number),
    .register_write    (register_write),
    .register_read     (register_read)
  );

  always #5 clk = ~clk;

  // Register bank stand-in: read data appears the cycle after a read op, writes land on the op edge.
  always @(posedge clk) begin
    if (register_operation == 2'd1 && register_number < NR) begin
      register_read <= bankMem[register_number];
    end
    if (register_operation == 2'd2 && register_number < NR) begin
      bankMem[register_number] <= register_write;
    end
  end

  task automatic applyStimulus(input int c, input bit on, input logic [1:0] op,
                               input logic [7:0] rg, input logic [DW-1:0] d);
    reqOn[c] = on;
    cOp[c]   = op;
    cReg[c]  = rg;
    cData[c] = d;
    client_req[c]               = on;
    client_op[c*2 +: 2]         = op;
    client_reg[c*8 +: 8]        = rg;
    client_wdata[c*DW +: DW]    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] randOp();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 2'd1;
    if (r < 8) return 2'd2;
    return (r == 8) ? 2'd0 : 2'd3;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_regop"}, register_operation, 0);
    checkOutput({tag, "_num"}, register_number, 0);
    checkOutput({tag, "_wr"}, register_write, 0);
    checkOutput({tag, "_ack"}, client_ack, 0);
    checkOutput({tag, "_err"}, client_err, 0);
    checkOutput({tag, "_rdata"}, client_rdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) applyStimulus(c, 1'b0, 2'd0, 8'd0, '0);
    @(negedge clk);
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    modelPtr = 0;
  endtask

  // One arbitration round starting at a negedge where the model expects IDLE.
  task automatic runAccess(input bit abortInCapture);
    int            g;
    bit            found;
    bit            legal;
    logic [1:0]    op;
    logic [7:0]    rg;
    logic [DW-1:0] d;
    logic [DW-1:0] expRd;
    logic [N-1:0]  oneHot;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_regop", register_operation, 0);
    checkOutput("idle_num", register_number, 0);
    checkOutput("idle_wr", register_write, 0);
    checkOutput("idle_ack", client_ack, 0);
    found = 1'b0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (modelPtr + k) % N;
      if (!found && reqOn[c]) begin
        found = 1'b1;
        g = c;
      end
    end
    if (!found) begin
      stepCycle();
      return;
    end
    op = cOp[g];
    rg = cReg[g];
    d  = cData[g];
    legal = ((op == 2'd1) || (op == 2'd2)) && (rg < NR);
    oneHot = '0;
    oneHot[g] = 1'b1;
    stepCycle();
    if (!legal) begin
      checkOutput("err_regop", register_operation, 0);
      checkOutput("err_ack", client_ack, oneHot);
      checkOutput("err_flag", client_err, 1);
      checkOutput("err_rdata", client_rdata, 0);
      checkOutput("err_busy", busy, 1);
      applyStimulus(g, 1'b0, op, rg, d);
      modelPtr = (g + 1) % N;
      stepCycle();
      return;
    end
    checkOutput("issue_regop", register_operation, op);
    checkOutput("issue_num", register_number, rg);
    checkOutput("issue_wr", register_write, (op == 2'd2) ? d : '0);
    checkOutput("issue_ack", client_ack, 0);
    checkOutput("issue_busy", busy, 1);
    applyStimulus(g, 1'b1, randOp(), 8'($urandom_range(0, 255)), $urandom);
    if (randomExtra) begin
      for (int c = 0; c < N; c++) begin
        if (!reqOn[c] && $urandom_range(0, 1) == 1) begin
          applyStimulus(c, 1'b1, randOp(), 8'($urandom_range(0, 7)), $urandom);
        end
      end
    end
    stepCycle();
    checkOutput("capture_regop", register_operation, 0);
    checkOutput("capture_ack", client_ack, 0);
    checkOutput("capture_busy", busy, 1);
    if (abortInCapture) begin
      rst_n = 1'b0;
      #1;
      checkAllZero("abort");
      for (int c = 0; c < N; c++) applyStimulus(c, 1'b0, 2'd0, 8'd0, '0);
      modelPtr = 0;
      @(negedge clk);
      checkOutput("abort_hold_ack", client_ack, 0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    stepCycle();
    expRd = (op == 2'd1) ? modelBank[rg] : '0;
    if (op == 2'd2) modelBank[rg] = d;
    checkOutput("complete_regop", register_operation, 3);
    checkOutput("complete_ack", client_ack, oneHot);
    checkOutput("complete_err", client_err, 0);
    checkOutput("complete_rdata", client_rdata, expRd);
    checkOutput("complete_busy", busy, 1);
    applyStimulus(g, 1'b0, cOp[g], cReg[g], cData[g]);
    modelPtr = (g + 1) % N;
    stepCycle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    randomExtra = 1'b0;
    modelPtr = 0;
    for (int r = 0; r < NR; r++) modelBank[r] = '0;
    applyReset();

    $display("[TB] client 0 write then client 1 read of reg 2");
    applyStimulus(0, 1'b1, 2'd2, 8'd2, 32'hDEADBEEF);
    runAccess(1'b0);
    applyStimulus(1, 1'b1, 2'd1, 8'd2, '0);
    runAccess(1'b0);

    $display("[TB] both clients requesting continuously from reset");
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 2'd2, 8'd1, 32'h11);
      applyStimulus(1, 1'b1, 2'd2, 8'd3, 32'h33);
      runAccess(1'b0);
    end
    for (int c = 0; c < N; c++) applyStimulus(c, 1'b0, 2'd0, 8'd0, '0);
    runAccess(1'b0);

    $display("[TB] illegal register and illegal op");
    applyStimulus(1, 1'b1, 2'd1, 8'd6, '0);
    runAccess(1'b0);
    applyStimulus(1, 1'b1, 2'd3, 8'd0, '0);
    runAccess(1'b0);

    $display("[TB] reset during capture");
    applyStimulus(0, 1'b1, 2'd2, 8'd4, 32'h44);
    runAccess(1'b0);
    applyStimulus(0, 1'b1, 2'd1, 8'd2, '0);
    runAccess(1'b1);
    applyStimulus(0, 1'b1, 2'd1, 8'd1, '0);
    applyStimulus(1, 1'b1, 2'd1, 8'd3, '0);
    runAccess(1'b0);
    runAccess(1'b0);
    applyStimulus(1, 1'b1, 2'd1, 8'd2, '0);
    runAccess(1'b0);

    $display("[TB] random traffic");
    randomExtra = 1'b1;
    repeat (80) begin
      for (int c = 0; c < N; c++) begin
        if (!reqOn[c] && $urandom_range(0, 2) != 0) begin
          applyStimulus(c, 1'b1, randOp(), 8'($urandom_range(0, 7)), $urandom);
        end
      end
      runAccess(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
